// File: rtl/filter_pkt_arbiter_if.sv
// Stream bundle between the per-channel packet buffers, the arbiter and the
// first-stage filter. The arbiter takes the slave view; the buffer/filter side takes master.
interface filter_pkt_arbiter_if #(
  parameter int NUM_CH = 4,
  parameter int DWIDTH = 256
);
  localparam int EWIDTH = $clog2(DWIDTH / 8);

  logic [NUM_CH*DWIDTH-1:0] in_data;
  logic [NUM_CH-1:0]        in_valid;
  logic [NUM_CH-1:0]        in_sop;
  logic [NUM_CH-1:0]        in_eop;
  logic [NUM_CH*EWIDTH-1:0] in_empty;
  logic [NUM_CH-1:0]        in_pkt_avail;
  logic [NUM_CH-1:0]        in_ready;
  logic                     out_pause;
  logic [DWIDTH-1:0]        out_data;
  logic                     out_valid;
  logic                     out_sop;
  logic                     out_eop;
  logic [EWIDTH-1:0]        out_empty;

  modport slave (
    input  in_data, in_valid, in_sop, in_eop, in_empty, in_pkt_avail, out_pause,
    output in_ready, out_data, out_valid, out_sop, out_eop, out_empty
  );

  modport master (
    output in_data, in_valid, in_sop, in_eop, in_empty, in_pkt_avail, out_pause,
    input  in_ready, out_data, out_valid, out_sop, out_eop, out_empty
  );
endinterface

// File: rtl/filter_pkt_arbiter.sv
// Round-robin packet arbiter: grants one channel per whole packet and forwards its
// beats, registered, to the first-stage filter, repairing and flagging bad framing.
module filter_pkt_arbiter #(
  parameter int NUM_CH = 4,
  parameter int DWIDTH = 256
) (
  input  logic                                         clk,
  input  logic                                         rst,
  filter_pkt_arbiter_if.slave                          bus,
  output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] cur_ch,
  output logic                                         busy,
  output logic                                         err_underrun,
  output logic                                         err_framing,
  output logic [31:0]                                  pkt_cnt
);
  localparam int CW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int EWIDTH = $clog2(DWIDTH / 8);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     rr_ptr_q;
  logic [CW-1:0]     grant_ch;
  logic [CW-1:0]     next_ptr;
  logic [CW:0]       cand;
  logic              grant_vld;
  logic              first_q;
  logic              accept;
  logic [DWIDTH-1:0] sel_data;
  logic              sel_valid, sel_sop, sel_eop;
  logic [EWIDTH-1:0] sel_empty;

  // Only the granted channel is ever looked at; everyone else is invisible.
  always_comb begin
    sel_data  = '0;
    sel_valid = 1'b0;
    sel_sop   = 1'b0;
    sel_eop   = 1'b0;
    sel_empty = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cur_ch == CW'(i)) begin
        sel_data  = bus.in_data[i*DWIDTH +: DWIDTH];
        sel_valid = bus.in_valid[i];
        sel_sop   = bus.in_sop[i];
        sel_eop   = bus.in_eop[i];
        sel_empty = bus.in_empty[i*EWIDTH +: EWIDTH];
      end
    end
  end

  always_comb begin
    grant_vld = 1'b0;
    grant_ch  = '0;
    cand      = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      cand = {1'b0, rr_ptr_q} + (CW+1)'(k);
      if (cand >= (CW+1)'(NUM_CH)) cand = cand - (CW+1)'(NUM_CH);
      if (!grant_vld && bus.in_pkt_avail[cand[CW-1:0]]) begin
        grant_vld = 1'b1;
        grant_ch  = cand[CW-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Pause only gates packet starts; once streaming, the packet always runs to eop.
  always_comb begin
    state_d      = state_q;
    bus.in_ready = '0;
    accept       = 1'b0;
    busy         = 1'b0;
    case (state_q)
      IDLE: begin
        if (!bus.out_pause && grant_vld) state_d = STREAM;
      end
      STREAM: begin
        busy         = 1'b1;
        bus.in_ready = NUM_CH'(1) << cur_ch;
        accept       = sel_valid;
        if (accept && sel_eop) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign next_ptr = (cur_ch == CW'(NUM_CH - 1)) ? '0 : cur_ch + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q     <= '0;
      cur_ch       <= '0;
      first_q      <= 1'b0;
      pkt_cnt      <= '0;
      err_underrun <= 1'b0;
      err_framing  <= 1'b0;
    end else begin
      if (state_q == IDLE && state_d == STREAM) begin
        cur_ch  <= grant_ch;
        first_q <= 1'b1;
      end
      if (state_q == STREAM) begin
        if (!sel_valid) err_underrun <= 1'b1;
        if (accept) begin
          first_q <= 1'b0;
          if (first_q != sel_sop) err_framing <= 1'b1;
          if (sel_eop) begin
            rr_ptr_q <= next_ptr;
            pkt_cnt  <= pkt_cnt + 32'd1;
          end
        end
      end
    end
  end

  // sop on the output comes from grant position, not from the input flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.out_sop   <= 1'b0;
      bus.out_eop   <= 1'b0;
      bus.out_empty <= '0;
    end else begin
      bus.out_valid <= accept;
      bus.out_sop   <= accept && first_q;
      bus.out_eop   <= accept && sel_eop;
      bus.out_empty <= (accept && sel_eop) ? sel_empty : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) bus.out_data <= sel_data;
  end
endmodule

// File: tb/tb_filter_pkt_arbiter.sv
// Directed bench: beats are pushed onto an expected queue as they are driven and a
// negedge monitor pops/compares every out_valid beat; status outputs are checked inline.
module tb_filter_pkt_arbiter;
  localparam int NUM_CH = 4;
  localparam int DWIDTH = 256;
  localparam int EWIDTH = 5;

  typedef struct packed {
    logic [DWIDTH-1:0] data;
    logic              sop;
    logic              eop;
    logic [EWIDTH-1:0] empty;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  cur_ch;
  logic        busy, err_underrun, err_framing;
  logic [31:0] pkt_cnt;

  beat_t expQ[$];
  beat_t expBeat;
  int    numChecks = 0;
  int    numFails  = 0;
  int    pktSeq    = 0;

  always #5 clk = ~clk;

  filter_pkt_arbiter_if #(.NUM_CH(NUM_CH), .DWIDTH(DWIDTH)) bus ();

  filter_pkt_arbiter #(.NUM_CH(NUM_CH), .DWIDTH(DWIDTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus.slave),
    .cur_ch       (cur_ch),
    .busy         (busy),
    .err_underrun (err_underrun),
    .err_framing  (err_framing),
    .pkt_cnt      (pkt_cnt)
  );

  always @(negedge clk) begin
    if (bus.out_valid !== 1'b0) begin
      numChecks++;
      if (expQ.size() == 0) begin
        numFails++;
        $display("[TB] FAIL unexpected_beat actual out_valid=%b sop=%b eop=%b required no beat",
                 bus.out_valid, bus.out_sop, bus.out_eop);
      end else begin
        expBeat = expQ.pop_front();
        if (bus.out_data !== expBeat.data || bus.out_sop !== expBeat.sop ||
            bus.out_eop !== expBeat.eop || bus.out_empty !== expBeat.empty) begin
          numFails++;
          $display("[TB] FAIL out_beat actual sop=%b eop=%b empty=%0d data=%h required sop=%b eop=%b empty=%0d data=%h",
                   bus.out_sop, bus.out_eop, bus.out_empty, bus.out_data[31:0],
                   expBeat.sop, expBeat.eop, expBeat.empty, expBeat.data[31:0]);
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] required);
    numChecks++;
    if (actual !== required) begin
      numFails++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, required);
    end
  endtask

  task automatic applyStimulus(input int ch, input logic [DWIDTH-1:0] data, input logic valid,
                               input logic sop, input logic eop, input logic [EWIDTH-1:0] empty);
    bus.in_data[ch*DWIDTH +: DWIDTH] = data;
    bus.in_valid[ch]                 = valid;
    bus.in_sop[ch]                   = sop;
    bus.in_eop[ch]                   = eop;
    bus.in_empty[ch*EWIDTH +: EWIDTH] = empty;
  endtask

  function automatic logic [DWIDTH-1:0] makeData(input int ch, input int b, input int pkt);
    logic [31:0] w;
    w = 32'hA500_0000 | (32'(pkt) << 16) | (32'(ch) << 8) | 32'(b);
    return {8{w}};
  endfunction

  task automatic clearInputs();
    bus.in_data      = '0;
    bus.in_valid     = '0;
    bus.in_sop       = '0;
    bus.in_eop       = '0;
    bus.in_empty     = '0;
    bus.in_pkt_avail = '0;
    bus.out_pause    = 1'b0;
  endtask

  task automatic resetDut();
    @(negedge clk);
    rst = 1'b1;
    clearInputs();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Waits (bounded) for a grant and checks who got it and how long it took.
  task automatic waitGrant(input int expCh, input int expWait);
    int  waited;
    bit  found;
    waited = 0;
    found  = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      waited++;
      if (|bus.in_ready) found = 1'b1;
    end
    checkOutput("grant_ready", 64'(bus.in_ready), 64'(1) << expCh);
    checkOutput("grant_latency", 64'(waited), 64'(expWait));
    checkOutput("grant_cur_ch", 64'(cur_ch), 64'(expCh));
    checkOutput("grant_busy", 64'(busy), 64'd1);
  endtask

  // Called at a negedge right after the grant; returns at the negedge after the eop edge.
  task automatic sendPacket(input int ch, input int nBeats, input logic [EWIDTH-1:0] lastEmpty,
                            input bit dropSop, input int gapBeat, input int strayBeat);
    beat_t       e;
    logic [DWIDTH-1:0] d;
    logic        sop, eop;
    pktSeq++;
    for (int b = 0; b < nBeats; b++) begin
      if (b == gapBeat) begin
        applyStimulus(ch, '0, 1'b0, 1'b0, 1'b0, '0);
        @(posedge clk);
        @(negedge clk);
      end
      d   = makeData(ch, b, pktSeq);
      sop = (b == 0) ? !dropSop : (b == strayBeat);
      eop = (b == nBeats - 1);
      applyStimulus(ch, d, 1'b1, sop, eop, eop ? lastEmpty : 5'd3);
      e.data  = d;
      e.sop   = (b == 0);
      e.eop   = eop;
      e.empty = eop ? lastEmpty : '0;
      expQ.push_back(e);
      @(posedge clk);
      @(negedge clk);
    end
    applyStimulus(ch, '0, 1'b0, 1'b0, 1'b0, '0);
    checkOutput("idle_gap_ready", 64'(bus.in_ready), 64'd0);
    checkOutput("idle_gap_busy", 64'(busy), 64'd0);
  endtask

  int order[5] = '{0, 1, 2, 3, 0};

  initial begin
    rst = 1'b1;
    clearInputs();
    repeat (3) @(negedge clk);
    checkOutput("rst_ready", 64'(bus.in_ready), 64'd0);
    checkOutput("rst_out_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_cur_ch", 64'(cur_ch), 64'd0);
    checkOutput("rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
    checkOutput("rst_errs", 64'({err_underrun, err_framing}), 64'd0);
    rst = 1'b0;

    $display("[TB] single channel packets");
    applyStimulus(3, {8{32'hDEAD_BEEF}}, 1'b1, 1'b1, 1'b1, 5'd1);
    bus.in_pkt_avail = 4'b0001;
    waitGrant(0, 1);
    sendPacket(0, 3, 5'd7, 1'b0, -1, -1);
    bus.in_pkt_avail = '0;
    checkOutput("single_pkt_cnt", 64'(pkt_cnt), 64'd1);
    checkOutput("single_errs", 64'({err_underrun, err_framing}), 64'd0);
    bus.in_pkt_avail = 4'b0001;
    waitGrant(0, 1);
    sendPacket(0, 1, 5'd31, 1'b0, -1, -1);
    bus.in_pkt_avail = '0;
    checkOutput("one_beat_pkt_cnt", 64'(pkt_cnt), 64'd2);
    applyStimulus(3, '0, 1'b0, 1'b0, 1'b0, '0);

    $display("[TB] fairness");
    resetDut();
    bus.in_pkt_avail = 4'b1111;
    for (int p = 0; p < 5; p++) begin
      waitGrant(order[p], 1);
      sendPacket(order[p], 2, 5'(p + 1), 1'b0, -1, -1);
    end
    bus.in_pkt_avail = '0;
    checkOutput("fair_pkt_cnt", 64'(pkt_cnt), 64'd5);

    $display("[TB] pause");
    resetDut();
    bus.out_pause    = 1'b1;
    bus.in_pkt_avail = 4'b0100;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("pause_hold", 64'(bus.in_ready), 64'd0);
    end
    bus.out_pause = 1'b0;
    waitGrant(2, 1);
    bus.out_pause = 1'b1;
    sendPacket(2, 3, 5'd4, 1'b0, -1, -1);
    bus.in_pkt_avail = '0;
    bus.out_pause    = 1'b0;
    checkOutput("pause_pkt_cnt", 64'(pkt_cnt), 64'd1);

    $display("[TB] underrun and framing");
    resetDut();
    bus.in_pkt_avail = 4'b0010;
    waitGrant(1, 1);
    sendPacket(1, 4, 5'd2, 1'b0, 2, -1);
    bus.in_pkt_avail = '0;
    checkOutput("underrun_flag", 64'(err_underrun), 64'd1);
    checkOutput("underrun_no_framing", 64'(err_framing), 64'd0);
    bus.in_pkt_avail = 4'b0010;
    waitGrant(1, 1);
    sendPacket(1, 3, 5'd9, 1'b1, -1, 2);
    bus.in_pkt_avail = '0;
    checkOutput("framing_flag", 64'(err_framing), 64'd1);
    checkOutput("framing_pkt_cnt", 64'(pkt_cnt), 64'd2);

    $display("[TB] reset mid-packet");
    resetDut();
    bus.in_pkt_avail = 4'b1000;
    waitGrant(3, 1);
    begin
      beat_t e;
      e.data  = makeData(3, 0, 99);
      e.sop   = 1'b1;
      e.eop   = 1'b0;
      e.empty = '0;
      applyStimulus(3, e.data, 1'b1, 1'b1, 1'b0, 5'd3);
      expQ.push_back(e);
      @(posedge clk);
      @(negedge clk);
      applyStimulus(3, makeData(3, 1, 99), 1'b1, 1'b0, 1'b0, 5'd3);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
    end
    checkOutput("midrst_ready", 64'(bus.in_ready), 64'd0);
    checkOutput("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("midrst_out_eop", 64'(bus.out_eop), 64'd0);
    checkOutput("midrst_pkt_cnt", 64'(pkt_cnt), 64'd0);
    checkOutput("midrst_errs", 64'({err_underrun, err_framing}), 64'd0);
    checkOutput("midrst_busy", 64'(busy), 64'd0);
    rst = 1'b0;
    clearInputs();
    bus.in_pkt_avail = 4'b1001;
    waitGrant(0, 1);
    sendPacket(0, 2, 5'd5, 1'b0, -1, -1);
    bus.in_pkt_avail = 4'b1000;
    waitGrant(3, 1);
    sendPacket(3, 2, 5'd6, 1'b0, -1, -1);
    bus.in_pkt_avail = '0;
    checkOutput("post_rst_pkt_cnt", 64'(pkt_cnt), 64'd2);

    repeat (3) @(negedge clk);
    checkOutput("queue_drained", 64'(expQ.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", numChecks, numFails);
    $finish;
  end
endmodule

// File: doc/filter_pkt_arbiter.md
FILTER_PKT_ARBITER -- requirements
Module: filter_pkt_arbiter

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of requesting packet channels (2..8).
REQ-002 SHALL have parameter DWIDTH, default 256, beat width in bits; empty width is EWIDTH=log2(DWIDTH/8)=5.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_data  input  NUM_CH*DWIDTH  per-channel beat data, channel i at slice i.
REQ-006 SHALL have ports in_valid, in_sop, in_eop  input  NUM_CH each  per-channel beat qualifiers.
REQ-007 SHALL have port in_empty  input  NUM_CH*EWIDTH  per-channel empty byte count, valid with eop.
REQ-008 SHALL have port in_pkt_avail  input  NUM_CH  channel holds at least one fully buffered packet.
REQ-009 SHALL have port in_ready  output  NUM_CH  per-channel beat accept, one-hot or zero.
REQ-010 SHALL have port out_pause  input  1  downstream filter path requests no new packet start.
REQ-011 SHALL have ports out_data/out_valid/out_sop/out_eop/out_empty  output  DWIDTH/1/1/1/EWIDTH  registered stream to the first-stage filter.
REQ-012 SHALL have port cur_ch  output  log2(NUM_CH)  channel currently granted.
REQ-013 SHALL have port busy  output  1  high while in STREAM.
REQ-014 SHALL have ports err_underrun, err_framing  output  1 each  sticky error flags.
REQ-015 SHALL have port pkt_cnt  output  32  packets forwarded since reset.

Function
REQ-016 SHALL implement FSM with states IDLE and STREAM.
REQ-017 IDLE: when out_pause=0 and any in_pkt_avail set, SHALL grant the first set channel at or after rr_ptr (round-robin, wrapping NUM_CH-1 to 0), load cur_ch, go to STREAM next cycle.
REQ-018 IDLE with out_pause=1 or no in_pkt_avail SHALL remain IDLE; all in_ready low.
REQ-019 STREAM: in_ready[cur_ch] SHALL be high, all others low; a beat is accepted when in_valid[cur_ch]&in_ready[cur_ch].
REQ-020 Accepted beat SHALL appear on out_* exactly one cycle later with out_valid=1; non-accepted cycles SHALL drive out_valid=0.
REQ-021 out_empty SHALL equal the accepted beat's empty when out_eop=1, else 0.
REQ-022 Accepted eop beat SHALL return FSM to IDLE, set rr_ptr=cur_ch+1 (mod NUM_CH), increment pkt_cnt (wrap at 2^32); minimum one idle cycle between packets.
REQ-023 out_pause SHALL be ignored in STREAM; a started packet always completes (filter state requires contiguous beats).
REQ-024 STREAM cycle with in_valid[cur_ch]=0 SHALL set err_underrun and produce an out_valid=0 bubble; FSM stays in STREAM.
REQ-025 First accepted beat of a grant lacking in_sop SHALL be forwarded with out_sop forced to 1 and set err_framing.
REQ-026 in_sop on a non-first beat SHALL set err_framing and be forwarded with out_sop=0.
REQ-027 Single-beat packet (sop and eop together) SHALL be valid: one STREAM cycle, then IDLE.
REQ-028 Inputs of non-granted channels SHALL be ignored entirely, including in_valid.

Reset
REQ-029 rst=1 SHALL force IDLE, rr_ptr=0, cur_ch=0, busy=0, in_ready=0, out_valid/out_sop/out_eop=0, out_empty=0, err flags=0, pkt_cnt=0 on the next edge.
REQ-030 rst asserted mid-packet SHALL abort the packet with no eop emitted; out_data value is don't-care under reset.
REQ-031 Error flags SHALL clear only on rst.

Verification
REQ-032 Single channel: ch0 avail, 3-beat packet (empty=7 on eop) -> grant after 1 IDLE cycle, out beats sop/-/eop on 3 consecutive cycles, out_empty=7 on last, pkt_cnt=1.
REQ-033 Fairness: all 4 channels continuously avail, 2-beat packets -> grant order 0,1,2,3,0, one idle cycle between packets, pkt_cnt=5.
REQ-034 Pause: out_pause=1 while ch2 avail -> no in_ready for 10 cycles; release -> ch2 granted next cycle; pause raised mid-packet -> packet completes.
REQ-035 Underrun/framing: granted ch1 drops in_valid one mid-packet cycle -> one bubble, err_underrun=1; first beat without sop -> out_sop=1, err_framing=1.
REQ-036 Reset mid-packet during beat 2 of 4 -> next cycle in_ready=0, out_valid=0, counters/flags 0, following arbitration starts at ch0.
